// File: rtl/noc_credit_out_buffer_pkg.sv
// Shared constants and helpers for the credit-mode NoC output buffer.
// FIFO entries are laid out as {tail, flit}; the tail lives at bit FLIT_WIDTH.
package noc_credit_out_buffer_pkg;

  localparam int unsigned FLIT_WIDTH_DEF           = 32'd80;
  localparam int unsigned OUT_BUFFER_DEPTH_DEF     = 32'd6;
  localparam int unsigned LOG_OUT_BUFFER_DEPTH_DEF = 32'd3;
  localparam int unsigned CREDITS_DEF              = 32'd6;
  localparam int unsigned LOG_CREDITS_DEF          = 32'd3;
  localparam int unsigned TAIL_BIT_DEF             = FLIT_WIDTH_DEF;

  // {send, credit return} events seen by the credit counter in one cycle
  typedef enum logic [1:0] {
    CR_HOLD   = 2'b00,
    CR_RETURN = 2'b01,
    CR_SEND   = 2'b10,
    CR_BOTH   = 2'b11
  } credit_evt_e;

  // Circular pointer increment for depths that need not be a power of two
  function automatic int unsigned wrap_next(input int unsigned ptr, input int unsigned depth);
    if (ptr == depth - 32'd1) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/noc_credit_out_buffer_if.sv
// NI-side push port plus credit-based link toward the switch.
interface noc_credit_out_buffer_if
  import noc_credit_out_buffer_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = FLIT_WIDTH_DEF
) ();

  logic [FLIT_WIDTH-1:0] data_in;
  logic                  data_tail;
  logic                  write;
  logic                  full;
  logic [FLIT_WIDTH-1:0] FLIT_out;
  logic                  VALID_out;
  logic                  FWDAUX1_out;
  logic                  BWDAUX1_in;
  logic                  BWDAUX2_in;
  logic                  BWDAUX3_in;
  logic                  credit_err;

  modport slave (
    input  data_in, data_tail, write, BWDAUX1_in, BWDAUX2_in, BWDAUX3_in,
    output full, FLIT_out, VALID_out, FWDAUX1_out, credit_err
  );

  modport master (
    output data_in, data_tail, write, BWDAUX1_in, BWDAUX2_in, BWDAUX3_in,
    input  full, FLIT_out, VALID_out, FWDAUX1_out, credit_err
  );

endinterface

// File: rtl/noc_credit_out_buffer_flit_fifo.sv
// Generic {tail, flit} circular FIFO with registered full; any depth >= 2.
// Pushes while full and pops while empty are ignored; no same-edge bypass.
module noc_credit_out_buffer_flit_fifo
  import noc_credit_out_buffer_pkg::*;
#(
  parameter int unsigned WIDTH     = FLIT_WIDTH_DEF + 32'd1,
  parameter int unsigned DEPTH     = OUT_BUFFER_DEPTH_DEF,
  parameter int unsigned LOG_DEPTH = LOG_OUT_BUFFER_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [WIDTH-1:0]     wdata_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic [LOG_DEPTH-1:0] count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam logic [LOG_DEPTH-1:0] ZERO = {LOG_DEPTH{1'b0}};
  localparam logic [LOG_DEPTH-1:0] ONE  = LOG_DEPTH'(32'd1);
  localparam logic [LOG_DEPTH-1:0] FULL = LOG_DEPTH'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH-1:0] count_q, count_d;
  logic                 full_q, full_d;
  logic                 push_s, pop_s;

  always_comb begin
    push_s   = push_i && !full_q;
    pop_s    = pop_i && (count_q != ZERO);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = LOG_DEPTH'(wrap_next(32'(wr_ptr_q), DEPTH));
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = LOG_DEPTH'(wrap_next(32'(rd_ptr_q), DEPTH));
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
    full_d = (count_d == FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= ZERO;
      rd_ptr_q <= ZERO;
      count_q  <= ZERO;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = (count_q == ZERO);

endmodule

// File: rtl/noc_credit_out_buffer.sv
// Credit-mode NoC output buffer: queues NI flits and issues at most one per
// cycle onto the link while the downstream buffer has advertised credits.
module noc_credit_out_buffer
  import noc_credit_out_buffer_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH           = FLIT_WIDTH_DEF,
  parameter int unsigned OUT_BUFFER_DEPTH     = OUT_BUFFER_DEPTH_DEF,
  parameter int unsigned LOG_OUT_BUFFER_DEPTH = LOG_OUT_BUFFER_DEPTH_DEF,
  parameter int unsigned CREDITS              = CREDITS_DEF,
  parameter int unsigned LOG_CREDITS          = LOG_CREDITS_DEF
) (
  input logic                      clk,
  input logic                      rst,
  noc_credit_out_buffer_if.slave   bus
);

  localparam logic [LOG_CREDITS-1:0]          CR_MAX  = LOG_CREDITS'(CREDITS);
  localparam logic [LOG_CREDITS-1:0]          CR_ONE  = LOG_CREDITS'(32'd1);
  localparam logic [LOG_CREDITS-1:0]          CR_ZERO = {LOG_CREDITS{1'b0}};
  localparam logic [LOG_OUT_BUFFER_DEPTH-1:0] CNT_ZERO = {LOG_OUT_BUFFER_DEPTH{1'b0}};

  logic [FLIT_WIDTH:0]               head_s;
  logic [LOG_OUT_BUFFER_DEPTH-1:0]   fifo_count_s;
  logic                              fifo_full_s;
  logic                              fifo_empty_unused_s;
  logic                              bwd_aux_unused_s;
  logic                              send_s;

  logic [LOG_CREDITS-1:0] credit_q, credit_d;
  logic                   err_q, err_d;
  logic                   valid_q, valid_d;
  logic [FLIT_WIDTH-1:0]  flit_q, flit_d;
  logic                   tail_q, tail_d;

  noc_credit_out_buffer_flit_fifo #(
    .WIDTH     (FLIT_WIDTH + 32'd1),
    .DEPTH     (OUT_BUFFER_DEPTH),
    .LOG_DEPTH (LOG_OUT_BUFFER_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.write),
    .pop_i   (send_s),
    .wdata_i ({bus.data_tail, bus.data_in}),
    .rdata_o (head_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_unused_s)
  );

  assign bwd_aux_unused_s = bus.BWDAUX2_in ^ bus.BWDAUX3_in;
  assign send_s = (fifo_count_s != CNT_ZERO) && (credit_q != CR_ZERO);

  // Credit counter, sticky overflow flag and the registered link outputs
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    valid_d  = send_s;
    flit_d   = flit_q;
    tail_d   = tail_q;
    case (credit_evt_e'({send_s, bus.BWDAUX1_in}))
      CR_SEND: credit_d = credit_q - CR_ONE;
      CR_RETURN: begin
        if (credit_q == CR_MAX) begin
          err_d = 1'b1;
        end else begin
          credit_d = credit_q + CR_ONE;
        end
      end
      default: credit_d = credit_q;
    endcase
    if (send_s) begin
      flit_d = head_s[FLIT_WIDTH-1:0];
      tail_d = head_s[FLIT_WIDTH];
    end else begin
      flit_d = flit_q;
      tail_d = tail_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q <= CR_MAX;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      flit_q   <= {FLIT_WIDTH{1'b0}};
      tail_q   <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      flit_q   <= flit_d;
      tail_q   <= tail_d;
    end
  end

  assign bus.full        = fifo_full_s;
  assign bus.VALID_out   = valid_q;
  assign bus.FLIT_out    = flit_q;
  assign bus.FWDAUX1_out = tail_q;
  assign bus.credit_err  = err_q;

endmodule

// File: tb/tb_noc_credit_out_buffer.sv
// Directed bench for noc_credit_out_buffer: latency, credit starvation,
// simultaneous events, credit overflow and reset mid-packet.
module tb_noc_credit_out_buffer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   sent;
  logic [79:0] last_flit;
  logic [79:0] got_q[$];

  noc_credit_out_buffer_if #(.FLIT_WIDTH(80)) bus ();

  noc_credit_out_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    bus.data_in = 80'h0;
    bus.data_tail = 1'b0;
    bus.write = 1'b0;
    bus.BWDAUX1_in = 1'b0;
    bus.BWDAUX2_in = 1'b1;
    bus.BWDAUX3_in = 1'b1;
    tick();
    tick();

    // reset values
    check_eq("rst_valid", 128'(bus.VALID_out), 128'h0);
    check_eq("rst_flit", 128'(bus.FLIT_out), 128'h0);
    check_eq("rst_tail", 128'(bus.FWDAUX1_out), 128'h0);
    check_eq("rst_full", 128'(bus.full), 128'h0);
    check_eq("rst_err", 128'(bus.credit_err), 128'h0);
    check_eq("rst_credit", 128'(dut.credit_q), 128'd6);
    rst = 1'b1;

    // idle
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_valid", 128'(bus.VALID_out), 128'h0);
      check_eq("idle_full", 128'(bus.full), 128'h0);
      check_eq("idle_err", 128'(bus.credit_err), 128'h0);
    end
    check_eq("idle_credit", 128'(dut.credit_q), 128'd6);

    // latency and throughput
    bus.write = 1'b1; bus.data_in = 80'h01; bus.data_tail = 1'b0;
    tick();
    check_eq("lat_c0_valid", 128'(bus.VALID_out), 128'h0);
    bus.data_in = 80'h02;
    tick();
    check_eq("lat_c1_valid", 128'(bus.VALID_out), 128'h1);
    check_eq("lat_c1_flit", 128'(bus.FLIT_out), 128'h01);
    check_eq("lat_c1_tail", 128'(bus.FWDAUX1_out), 128'h0);
    bus.data_in = 80'h03; bus.data_tail = 1'b1;
    tick();
    check_eq("lat_c2_valid", 128'(bus.VALID_out), 128'h1);
    check_eq("lat_c2_flit", 128'(bus.FLIT_out), 128'h02);
    check_eq("lat_c2_tail", 128'(bus.FWDAUX1_out), 128'h0);
    bus.write = 1'b0; bus.data_tail = 1'b0;
    tick();
    check_eq("lat_c3_valid", 128'(bus.VALID_out), 128'h1);
    check_eq("lat_c3_flit", 128'(bus.FLIT_out), 128'h03);
    check_eq("lat_c3_tail", 128'(bus.FWDAUX1_out), 128'h1);
    tick();
    check_eq("lat_c4_valid", 128'(bus.VALID_out), 128'h0);
    check_eq("lat_c4_hold", 128'(bus.FLIT_out), 128'h03);
    check_eq("lat_credit", 128'(dut.credit_q), 128'd3);
    bus.BWDAUX1_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.BWDAUX1_in = 1'b0;
    check_eq("ret_credit", 128'(dut.credit_q), 128'd6);
    check_eq("ret_err", 128'(bus.credit_err), 128'h0);

    // credit starvation: 14 back-to-back writes, only 6 go out
    sent = 0;
    last_flit = 80'h0;
    for (int k = 0; k < 14; k++) begin
      bus.write = 1'b1; bus.data_in = 80'h10 + 80'(k);
      tick();
      if (bus.VALID_out) begin
        sent++;
        last_flit = bus.FLIT_out;
      end
      if (k == 10) check_eq("starve_full_e10", 128'(bus.full), 128'h0);
      if (k == 11) check_eq("starve_full_e11", 128'(bus.full), 128'h1);
    end
    bus.write = 1'b0;
    check_eq("starve_sent", 128'(sent), 128'd6);
    check_eq("starve_last", 128'(last_flit), 128'h15);
    check_eq("starve_count", 128'(dut.u_fifo.count_q), 128'd6);
    check_eq("starve_credit", 128'(dut.credit_q), 128'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("starve_idle", 128'(bus.VALID_out), 128'h0);
    end
    bus.BWDAUX1_in = 1'b1;
    tick();
    bus.BWDAUX1_in = 1'b0;
    check_eq("pulse_c0_valid", 128'(bus.VALID_out), 128'h0);
    tick();
    check_eq("pulse_c1_valid", 128'(bus.VALID_out), 128'h1);
    check_eq("pulse_c1_flit", 128'(bus.FLIT_out), 128'h16);
    check_eq("pulse_c1_full", 128'(bus.full), 128'h0);
    tick();
    check_eq("pulse_c2_valid", 128'(bus.VALID_out), 128'h0);

    // continuous credit return with a backlog: one flit per cycle
    bus.BWDAUX1_in = 1'b1;
    tick();
    check_eq("sim_c0_valid", 128'(bus.VALID_out), 128'h0);
    check_eq("sim_c0_credit", 128'(dut.credit_q), 128'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("sim_valid", 128'(bus.VALID_out), 128'h1);
      check_eq("sim_flit", 128'(bus.FLIT_out), 128'h17 + 128'(i));
      check_eq("sim_credit", 128'(dut.credit_q), 128'd1);
    end
    bus.BWDAUX1_in = 1'b0;
    tick();
    check_eq("sim_last_flit", 128'(bus.FLIT_out), 128'h1a);
    check_eq("sim_last_credit", 128'(dut.credit_q), 128'd0);

    // refill to full, then write and send on the same edge
    for (int k = 0; k < 5; k++) begin
      bus.write = 1'b1; bus.data_in = 80'h20 + 80'(k);
      tick();
    end
    bus.write = 1'b0;
    check_eq("refill_full", 128'(bus.full), 128'h1);
    check_eq("refill_count", 128'(dut.u_fifo.count_q), 128'd6);
    bus.BWDAUX1_in = 1'b1;
    tick();
    bus.BWDAUX1_in = 1'b0;
    check_eq("ws_pre_valid", 128'(bus.VALID_out), 128'h0);
    bus.write = 1'b1; bus.data_in = 80'h99;
    tick();
    bus.write = 1'b0;
    check_eq("ws_valid", 128'(bus.VALID_out), 128'h1);
    check_eq("ws_flit", 128'(bus.FLIT_out), 128'h1b);
    check_eq("ws_count", 128'(dut.u_fifo.count_q), 128'd5);
    check_eq("ws_full", 128'(bus.full), 128'h0);
    bus.BWDAUX1_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.VALID_out) got_q.push_back(bus.FLIT_out);
    end
    bus.BWDAUX1_in = 1'b0;
    tick();
    if (bus.VALID_out) got_q.push_back(bus.FLIT_out);
    check_eq("drain_n", 128'(got_q.size()), 128'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) check_eq("drain_flit", 128'(got_q[i]), 128'h20 + 128'(i));
    end

    // credit overflow
    do_reset();
    check_eq("ovf_pre_err", 128'(bus.credit_err), 128'h0);
    check_eq("ovf_pre_credit", 128'(dut.credit_q), 128'd6);
    bus.BWDAUX1_in = 1'b1;
    tick();
    bus.BWDAUX1_in = 1'b0;
    check_eq("ovf_err", 128'(bus.credit_err), 128'h1);
    check_eq("ovf_credit", 128'(dut.credit_q), 128'd6);
    for (int i = 0; i < 3; i++) tick();
    check_eq("ovf_sticky", 128'(bus.credit_err), 128'h1);

    // reset mid-packet with 4 flits queued and a flit on the link
    do_reset();
    check_eq("mid_err_clr", 128'(bus.credit_err), 128'h0);
    for (int k = 0; k < 11; k++) begin
      bus.write = 1'b1; bus.data_in = 80'h30 + 80'(k);
      bus.data_tail = (k == 10);
      bus.BWDAUX1_in = (k == 9);
      tick();
    end
    bus.write = 1'b0; bus.data_tail = 1'b0; bus.BWDAUX1_in = 1'b0;
    check_eq("mid_pre_valid", 128'(bus.VALID_out), 128'h1);
    check_eq("mid_pre_flit", 128'(bus.FLIT_out), 128'h36);
    check_eq("mid_pre_count", 128'(dut.u_fifo.count_q), 128'd4);
    #1 rst = 1'b0;
    #1;
    check_eq("mid_async_valid", 128'(bus.VALID_out), 128'h0);
    check_eq("mid_async_flit", 128'(bus.FLIT_out), 128'h0);
    check_eq("mid_async_full", 128'(bus.full), 128'h0);
    tick();
    rst = 1'b1;
    sent = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.VALID_out) sent++;
    end
    check_eq("mid_no_stale", 128'(sent), 128'd0);
    check_eq("mid_credit", 128'(dut.credit_q), 128'd6);
    check_eq("mid_full", 128'(bus.full), 128'h0);
    check_eq("mid_count", 128'(dut.u_fifo.count_q), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
